// File: rtl/decoder_sweep_if.sv
// Select/enable/sweep-request bundle and registered one-hot result of decoder_sweep.
// The driver of the select and request side uses master; the decoder uses slave.
interface decoder_sweep_if #(
  parameter int SEL_W = 5
);
  localparam int OUT_W = 2 ** SEL_W;

  logic [SEL_W-1:0] In;
  logic             E;
  logic             ClrStart;
  logic [OUT_W-1:0] Out;
  logic             Busy;
  logic             Done;

  modport master (
    output In, E, ClrStart,
    input  Out, Busy, Done
  );

  modport slave (
    input  In, E, ClrStart,
    output Out, Busy, Done
  );
endinterface

// File: rtl/decoder_sweep.sv
// Registered N-to-2^N one-hot decoder with a sweep mode that walks every output once.
// Define DEC_ACTIVE_LOW_EN to make Out active-low (one-cold); Busy/Done stay active-high.
module decoder_sweep #(
  parameter int SEL_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  decoder_sweep_if.slave   bus
);
  localparam int OUT_W = 2 ** SEL_W;
  // One extra counter bit so the terminal value OUT_W is representable.
  localparam logic [SEL_W:0] CNT_END  = (SEL_W + 1)'(OUT_W);
  localparam logic [SEL_W:0] CNT_LAST = (SEL_W + 1)'(OUT_W - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_POL = '1;
`else
  localparam logic [OUT_W-1:0] OUT_POL = '0;
`endif

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0] word_d;
  logic [OUT_W-1:0] out_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ClrStart) begin
          // A sweep request wins over a simultaneous normal decode.
          state_d   = SWEEP;
          word_d[0] = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = (SEL_W + 1)'(1);
        end else if (bus.E) begin
          word_d[bus.In] = 1'b1;
        end
      end

      SWEEP: begin
        if (cnt_q == CNT_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (bus.E) word_d[bus.In] = 1'b1;
        end else begin
          word_d[cnt_q[SEL_W-1:0]] = 1'b1;
          busy_d = 1'b1;
          done_d = (cnt_q == CNT_LAST);
          cnt_d  = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= OUT_POL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= word_d ^ OUT_POL;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Out  = out_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// Directed bench for decoder_sweep: a SEL_W=5 instance and a SEL_W=3 instance.
// Expected Out values are inverted when DEC_ACTIVE_LOW_EN is defined.
module tb_decoder_sweep;
  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [31:0] INV5 = '1;
  localparam logic [7:0]  INV3 = '1;
`else
  localparam logic [31:0] INV5 = '0;
  localparam logic [7:0]  INV3 = '0;
`endif

  always #5 Clk = ~Clk;

  decoder_sweep_if #(.SEL_W(5)) bus5 ();
  decoder_sweep_if #(.SEL_W(3)) bus3 ();

  decoder_sweep #(.SEL_W(5)) dut5 (.Clk(Clk), .Reset(Reset), .bus(bus5.slave));
  decoder_sweep #(.SEL_W(3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(bus3.slave));

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus5.In = '0; bus5.E = 1'b1; bus5.ClrStart = 1'b1;
    bus3.In = '0; bus3.E = 1'b1; bus3.ClrStart = 1'b1;
    step();
    step();
    n_checks++;
    if (bus5.Out !== (32'h0 ^ INV5)) begin
      n_fail++; $display("FAIL reset_out5: got %h expected %h", bus5.Out, 32'h0 ^ INV5);
    end
    n_checks++;
    if (bus5.Busy !== 1'b0 || bus5.Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags5: busy=%b done=%b expected 0 0", bus5.Busy, bus5.Done);
    end
    n_checks++;
    if (bus3.Out !== (8'h0 ^ INV3)) begin
      n_fail++; $display("FAIL reset_out3: got %h expected %h", bus3.Out, 8'h0 ^ INV3);
    end
    bus5.E = 1'b0; bus5.ClrStart = 1'b0;
    bus3.E = 1'b0; bus3.ClrStart = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_enable();
    bus5.In = 5'd1; bus5.E = 1'b0;
    step();
    n_checks++;
    if (bus5.Out !== (32'h0000_0000 ^ INV5)) begin
      n_fail++; $display("FAIL enable_off: got %h expected %h", bus5.Out, 32'h0 ^ INV5);
    end
    bus5.E = 1'b1;
    step();
    n_checks++;
    if (bus5.Out !== (32'h0000_0002 ^ INV5)) begin
      n_fail++; $display("FAIL enable_on: got %h expected %h", bus5.Out, 32'h2 ^ INV5);
    end
  endtask

  task automatic test_index();
    logic [4:0]  sel [3] = '{5'd9, 5'd17, 5'd25};
    logic [31:0] exp [3] = '{32'h0000_0200, 32'h0002_0000, 32'h0200_0000};
    bus5.E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus5.In = sel[i];
      step();
      n_checks++;
      if (bus5.Out !== (exp[i] ^ INV5) || bus5.Busy !== 1'b0) begin
        n_fail++; $display("FAIL index_%0d: got %h busy=%b expected %h busy=0", sel[i], bus5.Out, bus5.Busy, exp[i] ^ INV5);
      end
    end
  endtask

  task automatic test_x_select();
    bus5.E = 1'b0; bus5.In = 'x;
    step();
    n_checks++;
    if (bus5.Out !== (32'h0 ^ INV5)) begin
      n_fail++; $display("FAIL x_select: got %h expected %h", bus5.Out, 32'h0 ^ INV5);
    end
    bus5.In = 5'd0;
  endtask

  task automatic test_full_sweep();
    logic [31:0] exp;
    bus5.E = 1'b1; bus5.In = 5'd3; bus5.ClrStart = 1'b1;
    step();
    bus5.ClrStart = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp = 32'h1 << i;
      n_checks++;
      if (bus5.Out !== (exp ^ INV5) || bus5.Busy !== 1'b1 || bus5.Done !== (i == 31)) begin
        n_fail++;
        $display("FAIL sweep_step_%0d: got %h busy=%b done=%b expected %h busy=1 done=%b",
                 i, bus5.Out, bus5.Busy, bus5.Done, exp ^ INV5, i == 31);
      end
      if (i == 31) bus5.In = 5'd7;
      step();
    end
    n_checks++;
    if (bus5.Out !== (32'h0000_0080 ^ INV5) || bus5.Busy !== 1'b0 || bus5.Done !== 1'b0) begin
      n_fail++; $display("FAIL sweep_exit: got %h busy=%b done=%b expected %h busy=0 done=0",
                         bus5.Out, bus5.Busy, bus5.Done, 32'h80 ^ INV5);
    end
  endtask

  task automatic test_ignored_request();
    int busy_cycles = 0;
    int done_count  = 0;
    bus5.E = 1'b0; bus5.ClrStart = 1'b1;
    step();
    bus5.ClrStart = 1'b0;
    for (int i = 0; i < 40 && bus5.Busy === 1'b1; i++) begin
      busy_cycles++;
      if (bus5.Done === 1'b1) done_count++;
      bus5.ClrStart = (i == 4 || i == 5);
      step();
    end
    bus5.ClrStart = 1'b0;
    n_checks++;
    if (busy_cycles != 32 || done_count != 1) begin
      n_fail++; $display("FAIL ignored_request: busy_cycles=%0d done_pulses=%0d expected 32 1", busy_cycles, done_count);
    end
    n_checks++;
    if (bus5.Out !== (32'h0 ^ INV5) || bus5.Busy !== 1'b0) begin
      n_fail++; $display("FAIL ignored_request_idle: got %h busy=%b expected %h busy=0", bus5.Out, bus5.Busy, 32'h0 ^ INV5);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles = 0;
    bus5.E = 1'b1; bus5.In = 5'd2; bus5.ClrStart = 1'b1;
    step();
    for (int i = 0; i < 32; i++) step();
    n_checks++;
    if (bus5.Out !== (32'h0000_0004 ^ INV5) || bus5.Busy !== 1'b0 || bus5.Done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %h busy=%b done=%b expected %h busy=0 done=0",
                         bus5.Out, bus5.Busy, bus5.Done, 32'h4 ^ INV5);
    end
    step();
    n_checks++;
    if (bus5.Out !== (32'h0000_0001 ^ INV5) || bus5.Busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: got %h busy=%b expected %h busy=1", bus5.Out, bus5.Busy, 32'h1 ^ INV5);
    end
    bus5.ClrStart = 1'b0;
    for (int i = 0; i < 40 && bus5.Busy === 1'b1; i++) begin
      busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles != 32 || bus5.Busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_len: busy_cycles=%0d busy=%b expected 32 0", busy_cycles, bus5.Busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit saw_done = 1'b0;
    bus5.E = 1'b0; bus5.ClrStart = 1'b1;
    step();
    bus5.ClrStart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus5.Done === 1'b1) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (bus5.Out !== (32'h0000_0400 ^ INV5)) begin
      n_fail++; $display("FAIL mid_sweep_word: got %h expected %h", bus5.Out, 32'h400 ^ INV5);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++;
    if (bus5.Out !== (32'h0 ^ INV5) || bus5.Busy !== 1'b0 || bus5.Done !== 1'b0) begin
      n_fail++; $display("FAIL mid_sweep_reset: got %h busy=%b done=%b expected %h busy=0 done=0",
                         bus5.Out, bus5.Busy, bus5.Done, 32'h0 ^ INV5);
    end
    for (int i = 0; i < 35; i++) begin
      if (bus5.Done === 1'b1) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done || bus5.Busy !== 1'b0 || bus5.Out !== (32'h0 ^ INV5)) begin
      n_fail++; $display("FAIL mid_sweep_no_done: saw_done=%b busy=%b out=%h expected 0 0 %h",
                         saw_done, bus5.Busy, bus5.Out, 32'h0 ^ INV5);
    end
  endtask

  task automatic test_small_width();
    logic [7:0] exp;
    bus3.E = 1'b1; bus3.In = 3'd6;
    step();
    n_checks++;
    if (bus3.Out !== (8'h40 ^ INV3)) begin
      n_fail++; $display("FAIL small_decode: got %h expected %h", bus3.Out, 8'h40 ^ INV3);
    end
    bus3.ClrStart = 1'b1;
    step();
    bus3.ClrStart = 1'b0; bus3.E = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = 8'h1 << i;
      n_checks++;
      if (bus3.Out !== (exp ^ INV3) || bus3.Busy !== 1'b1 || bus3.Done !== (i == 7)) begin
        n_fail++; $display("FAIL small_sweep_%0d: got %h busy=%b done=%b expected %h busy=1 done=%b",
                           i, bus3.Out, bus3.Busy, bus3.Done, exp ^ INV3, i == 7);
      end
      step();
    end
    n_checks++;
    if (bus3.Out !== (8'h0 ^ INV3) || bus3.Busy !== 1'b0 || bus3.Done !== 1'b0) begin
      n_fail++; $display("FAIL small_exit: got %h busy=%b done=%b expected %h busy=0 done=0",
                         bus3.Out, bus3.Busy, bus3.Done, 8'h0 ^ INV3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enable();
    test_index();
    test_x_select();
    test_full_sweep();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_sweep();
    test_small_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
